serial_subtractor: RTL

Bit-serial, LSB-first ripple subtractor computing diff = A - B - bin over WIDTH clock cycles using a single borrow flip-flop. It is the subtract direction of our ripple full-adder datapath, used by the program-counter and shifter path for decrement and compare operations where area matters more than latency. A one-cycle start pulse launches an operation. A one-cycle done pulse marks the result valid.

---
 rtl/serial_subtractor.sv | 126 ++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial, LSB-first ripple subtractor.
// Computes diff = a - b - bin (mod 2^WIDTH) over WIDTH cycles using one borrow flop.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   start          launch pulse, sampled only in IDLE
//   a, b, bin      minuend, subtrahend, borrow-in; captured on the accepting edge
//   busy           high while bits are being processed (WIDTH cycles)
//   done           one-cycle pulse; diff/bout/ovf valid
//   diff           result, held until the next operation completes
//   bout           unsigned borrow-out (a < b + bin)
//   ovf            signed two's-complement overflow
module serial_subtractor #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf
);

   localparam int unsigned CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             br_q, br_d;
   logic             bout_q, bout_d;
   logic             ovf_q, ovf_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             d_bit, br_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         diff_q  <= '0;
         br_q    <= 1'b0;
         bout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         diff_q  <= diff_d;
         br_q    <= br_d;
         bout_q  <= bout_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
      end
   end

   // One full-subtractor cell on the current LSBs of the operand shifters.
   always_comb begin
      d_bit   = a_q[0] ^ b_q[0] ^ br_q;
      br_next = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      diff_d  = diff_q;
      br_d    = br_q;
      bout_d  = bout_q;
      ovf_d   = ovf_q;
      cnt_d   = cnt_q;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               br_d    = bin;
               res_d   = '0;
               cnt_d   = '0;
               state_d = StShift;
            end
         end
         StShift: begin
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            br_d  = br_next;
            res_d = {d_bit, res_q[WIDTH-1:1]};
            if (cnt_q == LastCnt) begin
               // br_q here is the borrow into the MSB.
               diff_d  = {d_bit, res_q[WIDTH-1:1]};
               bout_d  = br_next;
               ovf_d   = br_q ^ br_next;
               cnt_d   = '0;
               state_d = StDone;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign busy = (state_q == StShift);
   assign done = (state_q == StDone);
   assign diff = diff_q;
   assign bout = bout_q;
   assign ovf  = ovf_q;

endmodule
